// File: rtl/approx_metrics_pkg.sv
// Shared types and default widths for the approximate-adder error monitor.
package approx_metrics_pkg;
   localparam int N_DEF     = 16;
   localparam int CNT_W_DEF = 32;
   localparam int ACC_W_DEF = 48;

   localparam logic [ACC_W_DEF-1:0] SAT_MAX_DEF = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/approx_ed_stage.sv
// Stage 1: recompute the exact N-bit sum and register |s_approx - exact|.
module approx_ed_stage #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         vld_in,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] s_approx,
   output logic         vld_out,
   output logic [N-1:0] ed
);
   logic [N-1:0] exact, diff;

   // carry-out dropped on purpose: the adder under test is compared at N bits
   assign exact = a + b;
   assign diff  = (s_approx >= exact) ? (s_approx - exact) : (exact - s_approx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_out <= 1'b0;
         ed      <= '0;
      end else begin
         vld_out <= vld_in;
         if (vld_in) ed <= diff;
      end
   end
endmodule

// File: rtl/approx_err_monitor.sv
// Error-metric accumulator: count, saturating sum and max of error distance over a run.
module approx_err_monitor
   import approx_metrics_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic [N-1:0]     s_approx,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] sum_ed,
   output logic [N-1:0]     max_ed,
   output logic [CNT_W-1:0] sample_count,
   output logic             overflow
);
   localparam logic [ACC_W-1:0] SAT_MAX = '1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] num_lat, acc_cnt;
   logic             start_ok, accept, vld1, vld2;
   logic [N-1:0]     ed1, ed2;
   logic [ACC_W:0]   sum_nxt;

   assign in_ready = (state == S_RUN) && (acc_cnt < num_lat);
   assign accept   = in_valid && in_ready;
   assign start_ok = start && (num_samples != '0) && ((state == S_IDLE) || (state == S_DONE));
   assign busy     = (state == S_RUN) || (state == S_DRAIN);
   assign done     = (state == S_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start_ok) state_nxt = S_RUN;
         S_RUN:          if (accept && (acc_cnt == num_lat - CNT_W'(1))) state_nxt = S_DRAIN;
         // stage 2 content lands on the same edge we leave DRAIN
         S_DRAIN:        if (!vld1) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         num_lat <= '0;
         acc_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            num_lat <= num_samples;
            acc_cnt <= '0;
         end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
         end
      end
   end

   approx_ed_stage #(.N(N)) u_ed (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld_in   (accept),
      .a        (a),
      .b        (b),
      .s_approx (s_approx),
      .vld_out  (vld1),
      .ed       (ed1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld2 <= 1'b0;
         ed2  <= '0;
      end else begin
         vld2 <= vld1;
         if (vld1) ed2 <= ed1;
      end
   end

   assign sum_nxt = {1'b0, sum_ed} + (ACC_W+1)'(ed2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count    <= '0;
         sum_ed       <= '0;
         max_ed       <= '0;
         sample_count <= '0;
         overflow     <= 1'b0;
      end else if (start_ok) begin
         err_count    <= '0;
         sum_ed       <= '0;
         max_ed       <= '0;
         sample_count <= '0;
         overflow     <= 1'b0;
      end else if (vld2) begin
         sample_count <= sample_count + CNT_W'(1);
         if (ed2 != '0)    err_count <= err_count + CNT_W'(1);
         if (ed2 > max_ed) max_ed    <= ed2;
         if (sum_nxt[ACC_W]) begin
            sum_ed   <= SAT_MAX;
            overflow <= 1'b1;
         end else begin
            sum_ed <= sum_nxt[ACC_W-1:0];
         end
      end
   end
endmodule
